// File: rtl/cnt_modn.sv
// Modulo-MOD up/down counter with synchronous load, one-cycle wrap pulse and a half-range flag.
// Define CNT_MODN_HOUR12_EN to fold disp into a 12-hour style range (0 shown as MOD/2).
module cnt_modn #(
    parameter int MOD = 24,
    parameter int W   = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry,
    output logic         half,
    output logic [W-1:0] disp
);

    // The modulus may equal 2**W, so it is only representable with one extra bit.
    localparam logic [W:0]   MOD_EXT  = (W+1)'(MOD);
    localparam logic [W-1:0] MAX_VAL  = W'(MOD - 1);
    localparam logic [W-1:0] HALF_VAL = W'(MOD / 2);

    logic [W-1:0] value_q, value_d;
    logic         carry_q, carry_d;
    logic         half_q,  half_d;

    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        if (load) begin
            value_d = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
        end else if (en) begin
            if (up) begin
                if (value_q == MAX_VAL) begin
                    value_d = '0;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q + W'(1);
                end
            end else begin
                if (value_q == '0) begin
                    value_d = MAX_VAL;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q - W'(1);
                end
            end
        end
        // Derived from value_d so the flag always matches the value it is registered with.
        half_d = (value_d >= HALF_VAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            carry_q <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
            half_q  <= half_d;
        end
    end

    assign value = value_q;
    assign carry = carry_q;
    assign half  = half_q;

`ifdef CNT_MODN_HOUR12_EN
    // value < MOD <= 2*HALF_VAL+1, so one conditional subtract replaces the modulo.
    logic [W-1:0] fold;
    always_comb begin
        fold = (value_q >= HALF_VAL) ? (value_q - HALF_VAL) : value_q;
        if ((fold == '0) || (fold == HALF_VAL)) begin
            disp = HALF_VAL;
        end else begin
            disp = fold;
        end
    end
`else
    assign disp = value_q;
`endif

endmodule

// File: doc/cnt_modn.md
CNT_MODN -- requirements
Module: cnt_modn

Interface
REQ-001 Parameter MOD, default 24: counter modulus; legal range 2..(2**W).
REQ-002 Parameter W, default 7: width of value, load_val and disp; SHALL satisfy 2**W >= MOD.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port en  input  1  count enable; one step per clk cycle while high.
REQ-006 Port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 Port load  input  1  synchronous load strobe.
REQ-008 Port load_val  input  W  value to load.
REQ-009 Port value  output  W  current count, registered, range 0..MOD-1.
REQ-010 Port carry  output  1  registered one-cycle wrap/borrow pulse.
REQ-011 Port half  output  1  registered level; 1 when value >= MOD/2 (integer division), else 0.
REQ-012 Port disp  output  W  display value (see Configuration).

Function
REQ-013 Priority per cycle SHALL be rst > load > en; the lower-priority action is ignored.
REQ-014 load=1: value <= load_val if load_val < MOD, else value <= 0; carry <= 0 in that cycle.
REQ-015 en=1, up=1, value < MOD-1: value <= value+1, carry <= 0.
REQ-016 en=1, up=1, value == MOD-1: value <= 0, carry <= 1.
REQ-017 en=1, up=0, value > 0: value <= value-1, carry <= 0.
REQ-018 en=1, up=0, value == 0: value <= MOD-1, carry <= 1.
REQ-019 en=0 and load=0: value holds, carry <= 0.
REQ-020 carry SHALL be high for exactly one cycle per wrap and SHALL coincide with the cycle in which value first shows the wrapped value.
REQ-021 half SHALL be registered and updated from the same next-state value as value, so half and value are never inconsistent in any cycle.
REQ-022 No arithmetic result SHALL exceed W bits; value never leaves 0..MOD-1, including after load of an out-of-range value.
REQ-023 Direction changes SHALL take effect on the same cycle as the up input changes; no pipeline latency beyond the single register stage.

Reset
REQ-024 rst=1 at a rising clk edge: value <= 0, carry <= 0, half <= 0, regardless of en and load.
REQ-025 Reset asserted mid-count SHALL not generate a carry pulse; the first cycle after reset release behaves as from value 0.
REQ-026 Behaviour before the first reset is undefined; the bench SHALL reset first.

Configuration
REQ-027 Macro CNT_MODN_HOUR12_EN: when defined, disp = value mod (MOD/2), with 0 replaced by MOD/2 (MOD=24: 0->12, 13->1, 12->12, 23->11); combinational from registered value.
REQ-028 When CNT_MODN_HOUR12_EN is undefined, disp = value; the port remains present with identical width.

Verification
REQ-029 MOD=24, rst 1 cycle then en=1, up=1 for 24 cycles -> value 0,1..23,0; carry high only with value=0 at cycle 24; half rises at value 12, falls at 0.
REQ-030 load=1, load_val=5, en=1 same cycle -> value=5, carry=0; next cycle en=1, up=0 x6 -> 4,3,2,1,0,23 with carry=1 only at 23.
REQ-031 load_val=30 (>= MOD) -> value=0, carry=0, half=0.
REQ-032 Count up to 23, assert rst together with en -> value=0, carry=0 (no wrap pulse).
REQ-033 MOD=60, W=6, en toggling every other cycle from 58 -> value 58,58,59,59,0 with one carry cycle; en=0 holds carry low.
REQ-034 With CNT_MODN_HOUR12_EN defined, sweep 0..23 -> disp 12,1..11,12,1..11; undefined -> disp equals value every cycle.
